// File: rtl/game_pkg.sv
// Shared game constants and types for the ball (projectile) controller.
package game_pkg;

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_FLY      = 2'd1,
        ST_IMPACT   = 2'd2,
        ST_COOLDOWN = 2'd3
    } ball_state_e;

    localparam logic [9:0]  HIT_HALF_W     = 10'd32;
    localparam logic [9:0]  HIT_HALF_H     = 10'd48;
    localparam logic [9:0]  SPAWN_DX_RIGHT = 10'd40;
    localparam int          SPAWN_DX_LEFT  = -16;
    localparam logic [9:0]  SPAWN_DY       = 10'd20;
    localparam logic [10:0] SCREEN_X_MAX   = 11'd630;

    localparam logic [9:0]  SPAWN_DX_LEFT_MAG = 10'(-SPAWN_DX_LEFT);

    // Distance between two unsigned coordinates without wrapping below zero.
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

endpackage

// File: rtl/ball_hitbox.sv
// Combinational overlap test between the ball origin and a target sprite origin.
module ball_hitbox
    import game_pkg::*;
(
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] tgt_x,
    input  logic [9:0] tgt_y,
    output logic       hit
);

    logic [9:0] dx_s;
    logic [9:0] dy_s;

    // Box overlap on both axes.
    always_comb begin
        dx_s = abs_diff(ball_x, tgt_x);
        dy_s = abs_diff(ball_y, tgt_y);
        hit  = (dx_s < HIT_HALF_W) && (dy_s < HIT_HALF_H);
    end

endmodule

// File: rtl/ball_ctrl.sv
// Ball launch / flight / impact / cooldown controller for one player.
module ball_ctrl
    import game_pkg::*;
#(
    parameter int BALL_SPEED      = 6,
    parameter int BALL_DAMAGE     = 15,
    parameter int COOLDOWN_FRAMES = 120,
    parameter int IMPACT_FRAMES   = 12
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       summon_ball,
    input  logic       face,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic [9:0] opp_x,
    input  logic [9:0] opp_y,
    input  logic       ending,
    output logic       ball_ready,
    output logic       ball_active,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [2:0] ball_frame,
    output logic [9:0] damage
);

    localparam int CNT_MAX_RAW = (COOLDOWN_FRAMES > IMPACT_FRAMES) ? COOLDOWN_FRAMES : IMPACT_FRAMES;
    localparam int CNT_MAX     = (CNT_MAX_RAW > 15) ? CNT_MAX_RAW : 15;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);

    localparam logic [9:0]       SPEED     = 10'(BALL_SPEED);
    localparam logic [9:0]       DMG       = 10'(BALL_DAMAGE);
    localparam logic [CNT_W-1:0] IMP_LAST  = CNT_W'(IMPACT_FRAMES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_FRAMES - 1);

    ball_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       ball_x_q, ball_x_d;
    logic [9:0]       ball_y_q, ball_y_d;
    logic             dir_q, dir_d;
    logic [9:0]       damage_q, damage_d;
    logic [2:0]       ball_frame_q, ball_frame_d;
    logic             ball_ready_q, ball_ready_d;
    logic             ball_active_q, ball_active_d;

    logic             hit_s;
    logic [10:0]      spawn_r_sum_s;
    logic [10:0]      step_r_sum_s;
    logic [10:0]      spawn_y_sum_s;
    logic [9:0]       spawn_x_s;
    logic [9:0]       spawn_y_s;
    logic             off_screen_s;

    ball_hitbox u_hitbox (
        .ball_x (ball_x_q),
        .ball_y (ball_y_q),
        .tgt_x  (opp_x),
        .tgt_y  (opp_y),
        .hit    (hit_s)
    );

    // Spawn position (saturating, never wraps) and screen-exit test.
    always_comb begin
        spawn_r_sum_s = {1'b0, player_x} + {1'b0, SPAWN_DX_RIGHT};
        spawn_y_sum_s = {1'b0, player_y} + {1'b0, SPAWN_DY};
        step_r_sum_s  = {1'b0, ball_x_q} + {1'b0, SPEED};
        if (face) begin
            if (player_x < SPAWN_DX_LEFT_MAG) begin
                spawn_x_s = 10'd0;
            end else begin
                spawn_x_s = player_x - SPAWN_DX_LEFT_MAG;
            end
        end else begin
            if (spawn_r_sum_s[10]) begin
                spawn_x_s = 10'h3FF;
            end else begin
                spawn_x_s = spawn_r_sum_s[9:0];
            end
        end
        if (spawn_y_sum_s[10]) begin
            spawn_y_s = 10'h3FF;
        end else begin
            spawn_y_s = spawn_y_sum_s[9:0];
        end
        if (dir_q) begin
            off_screen_s = (ball_x_q < SPEED);
        end else begin
            off_screen_s = (step_r_sum_s > SCREEN_X_MAX);
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dir_d    = dir_q;
        damage_d = 10'd0;
        case (state_q)
            ST_READY: begin
                if (summon_ball && ending) begin
                    state_d  = ST_FLY;
                    cnt_d    = '0;
                    ball_x_d = spawn_x_s;
                    ball_y_d = spawn_y_s;
                    dir_d    = face;
                end else begin
                    state_d  = ST_READY;
                end
            end
            ST_FLY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Abort beats hit, hit beats exit; the hit test uses the pre-step position.
                if (!ending) begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = '0;
                end else if (hit_s) begin
                    state_d  = ST_IMPACT;
                    cnt_d    = '0;
                    damage_d = DMG;
                end else if (off_screen_s) begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = '0;
                end else if (dir_q) begin
                    ball_x_d = ball_x_q - SPEED;
                end else begin
                    ball_x_d = step_r_sum_s[9:0];
                end
            end
            ST_IMPACT: begin
                if (cnt_q == IMP_LAST) begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COOLDOWN: begin
                if (cnt_q == COOL_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_READY;
                cnt_d   = '0;
            end
        endcase

        ball_active_d = (state_d == ST_FLY) || (state_d == ST_IMPACT);
        ball_ready_d  = (state_d == ST_READY) && ending;
        case (state_d)
            ST_FLY:    ball_frame_d = {1'b0, cnt_d[3:2]};
            ST_IMPACT: ball_frame_d = 3'd4 + 3'(cnt_d >> 2);
            default:   ball_frame_d = 3'd0;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q       <= ST_READY;
            cnt_q         <= '0;
            ball_x_q      <= 10'd0;
            ball_y_q      <= 10'd0;
            dir_q         <= 1'b0;
            damage_q      <= 10'd0;
            ball_frame_q  <= 3'd0;
            ball_ready_q  <= 1'b0;
            ball_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            dir_q         <= dir_d;
            damage_q      <= damage_d;
            ball_frame_q  <= ball_frame_d;
            ball_ready_q  <= ball_ready_d;
            ball_active_q <= ball_active_d;
        end
    end

    assign ball_ready  = ball_ready_q;
    assign ball_active = ball_active_q;
    assign ball_x      = ball_x_q;
    assign ball_y      = ball_y_q;
    assign ball_frame  = ball_frame_q;
    assign damage      = damage_q;

endmodule

// File: doc/ball_ctrl.md
BALL_CTRL -- requirements
Module: ball_ctrl

Interface
REQ-001 Parameter BALL_SPEED, 6: ball x step per frame, in pixels.
REQ-002 Parameter BALL_DAMAGE, 15: damage delivered on a hit.
REQ-003 Parameter COOLDOWN_FRAMES, 120: frames in COOLDOWN before ball_ready reasserts.
REQ-004 Parameter IMPACT_FRAMES, 12: frames the impact animation is held.
REQ-005 frame_clk  in  1  frame-rate clock; single clock domain.
REQ-006 Reset  in  1  synchronous, active-high reset, sampled on the rising edge of frame_clk.
REQ-007 summon_ball  in  1  one-frame launch request from the owning player.
REQ-008 face  in  1  owner facing: 0 = right, 1 = left.
REQ-009 player_x, player_y  in  10 each  owner sprite origin.
REQ-010 opp_x, opp_y  in  10 each  opponent sprite origin.
REQ-011 ending  in  1  game-running qualifier: 1 = running.
REQ-012 ball_ready  out  1  launch permitted; feeds the owner's ball_ready input.
REQ-013 ball_active  out  1  ball drawn (FLY or IMPACT).
REQ-014 ball_x, ball_y  out  10 each  ball sprite origin.
REQ-015 ball_frame  out  3  sprite animation index.
REQ-016 damage  out  10  damage to the opponent for this frame; feeds the opponent's damage input.

Function
REQ-017 The FSM SHALL have four states: READY, FLY, IMPACT, COOLDOWN; all state and outputs are registered on frame_clk.
REQ-018 READY: ball_ready = ending; ball_active = 0; damage = 0.
REQ-019 READY with summon_ball = 1 and ending = 1 SHALL go to FLY next frame.
  - Launch latches ball_y = player_y + 20.
  - Launch latches ball_x = player_x + 40 when face = 0, else player_x - 16 (10-bit wrap is not permitted; clamp to 0).
  - Launch latches the direction from face.
REQ-020 summon_ball SHALL be ignored in every state other than READY, and whenever ending = 0.
REQ-021 FLY: each frame, the hit test SHALL run on the current ball_x/ball_y before the position is updated.
  - Hit: |ball_x - opp_x| < 32 AND |ball_y - opp_y| < 48, using unsigned-safe differences.
REQ-022 FLY with a hit SHALL go to IMPACT.
  - damage = BALL_DAMAGE for exactly that one frame; otherwise damage = 0.
  - ball_x is held at its current value.
REQ-023 FLY without a hit SHALL step ball_x by +BALL_SPEED (right) or -BALL_SPEED (left).
  - Off-screen exit: if moving right and ball_x + BALL_SPEED > 630, or moving left and ball_x < BALL_SPEED, go to COOLDOWN with no damage.
  - A hit takes priority over off-screen exit in the same frame.
REQ-024 ball_frame SHALL advance by 1 every 4 frames in FLY, wrapping in the range 0-3; it is 4 + (counter/4) during IMPACT; it is 0 otherwise.
REQ-025 IMPACT SHALL last IMPACT_FRAMES frames with ball_active = 1, then go to COOLDOWN.
REQ-026 COOLDOWN SHALL clear ball_active, count COOLDOWN_FRAMES frames, then go to READY; ball_ready = 0 throughout.
REQ-027 damage SHALL never be asserted for two consecutive frames; at most one hit is delivered per launch.
REQ-028 ending falling to 0 mid-FLY SHALL abort the flight to COOLDOWN with no damage; IMPACT and COOLDOWN proceed unaffected.

Reset
REQ-029 Reset SHALL force the following, overriding any in-progress flight, impact or cooldown:
  - state = READY, counters = 0.
  - ball_x = 0, ball_y = 0, ball_frame = 0.
  - damage = 0, ball_active = 0, ball_ready = 0.
  - ball_ready may rise on the first frame after Reset if ending = 1.

Structure
REQ-030 The state enum, the hitbox half-widths (32, 48), the spawn offsets (40, -16, 20) and the screen limit (630) SHALL live in the shared package game_pkg.
REQ-031 The hit comparison SHALL be a combinational sub-module named ball_hitbox (inputs: two positions; output: hit); everything else stays in ball_ctrl.

Verification
REQ-032 Launch: player (80,300), face = 0, ending = 1, summon pulse -> next frame FLY, ball (120,320); frame after, ball_x = 126; ball_ready = 0.
REQ-033 Hit: opponent at (200,300), right-moving ball -> one frame of damage = 15 when |dx| < 32; then IMPACT for 12 frames; then COOLDOWN; ball_ready returns after 120 more frames.
REQ-034 Miss: no opponent in path, face = 1, player_x = 80 -> ball leaves at the left edge, reaches COOLDOWN with damage never nonzero.
REQ-035 Ignored requests: summon pulses during FLY, IMPACT and COOLDOWN, and during READY with ending = 0 -> no state change.
REQ-036 Reset mid-FLY at ball_x = 300 -> next frame READY with all outputs at their reset values; a fresh launch works.
REQ-037 Abort: ending dropped mid-FLY -> COOLDOWN on the next frame, damage = 0.
